// File: rtl/payload_buffer_pkg.sv
// Shared constants and state encoding for the payload ingress buffer.
// Geometry is derived from MAX_BYTES/WORD_BYTES so the store and counters stay consistent.
package payload_buffer_pkg;

  localparam int unsigned MAX_BYTES  = 64;
  localparam int unsigned WORD_BYTES = 8;
  localparam int unsigned NUM_WORDS  = MAX_BYTES / WORD_BYTES;
  localparam int unsigned WORD_W     = WORD_BYTES * 8;
  localparam int unsigned PTR_W      = $clog2(NUM_WORDS);
  localparam int unsigned LANE_W     = $clog2(WORD_BYTES);
  localparam int unsigned CNT_W      = $clog2(MAX_BYTES + 1);

  localparam logic [7:0] PAD_BYTE = 8'h00;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FILL,
    ST_DISCARD,
    ST_PAD,
    ST_LAUNCH,
    ST_WAIT
  } state_t;

endpackage

// File: rtl/payload_buffer_if.sv
// Byte-stream ingress plus loader-side read/handshake bus of the payload buffer.
// slave = buffer view; master = upstream source and loader view.
interface payload_buffer_if;
  import payload_buffer_pkg::*;

  logic [7:0]        s_data;
  logic              s_valid;
  logic              s_last;
  logic              s_ready;
  logic [PTR_W-1:0]  mem_addr;
  logic              mem_rd_en;
  logic [WORD_W-1:0] data_out;
  logic              start;
  logic              loader_ready;

  modport slave (
    input  s_data, s_valid, s_last, mem_addr, mem_rd_en, loader_ready,
    output s_ready, data_out, start
  );

  modport master (
    output s_data, s_valid, s_last, mem_addr, mem_rd_en, loader_ready,
    input  s_ready, data_out, start
  );

endinterface

// File: rtl/payload_word_ram.sv
// 8 x 64-bit word store: one write port, one registered read port with enable.
// Array is not reset; only the read register is.
module payload_word_ram
  import payload_buffer_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [PTR_W-1:0]  wr_addr,
  input  logic [WORD_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [PTR_W-1:0]  rd_addr,
  output logic [WORD_W-1:0] rd_data
);

  logic [WORD_W-1:0] mem [NUM_WORDS];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Same-edge write/read to one word returns the previous contents.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)       rd_data <= '0;
    else if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/payload_buffer.sv
// Packet ingress buffer: packs bytes little-endian into 8 words, pads/truncates to
// 64 bytes, pulses start, then holds the store until a loader_ready rising edge.
module payload_buffer
  import payload_buffer_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  payload_buffer_if.slave  bus,
  output logic [CNT_W-1:0] byte_count,
  output logic             overflow
);

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt_nxt, base_cnt;
  logic              ovf_nxt;
  logic [PTR_W-1:0]  wptr, wptr_nxt, base_ptr;
  logic [WORD_W-1:0] acc, acc_nxt, word;
  logic [LANE_W-1:0] lane;
  logic              lr_q;
  logic              live;
  logic              accept;
  logic              wr_en;
  logic [PTR_W-1:0]  wr_addr;
  logic [WORD_W-1:0] wr_data;

  // live keeps s_ready low while reset is asserted even though state sits in IDLE.
  assign bus.s_ready = live && (state == ST_IDLE || state == ST_FILL || state == ST_DISCARD);
  assign bus.start   = (state == ST_LAUNCH);
  assign accept      = bus.s_valid && bus.s_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      byte_count <= '0;
      overflow   <= 1'b0;
      wptr       <= '0;
      acc        <= '0;
      lr_q       <= 1'b0;
      live       <= 1'b0;
    end else begin
      state      <= state_nxt;
      byte_count <= cnt_nxt;
      overflow   <= ovf_nxt;
      wptr       <= wptr_nxt;
      acc        <= acc_nxt;
      lr_q       <= bus.loader_ready;
      live       <= 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = byte_count;
    ovf_nxt   = overflow;
    wptr_nxt  = wptr;
    acc_nxt   = acc;
    wr_en     = 1'b0;
    wr_addr   = wptr;
    wr_data   = acc;
    base_cnt  = (state == ST_IDLE) ? '0 : byte_count;
    base_ptr  = (state == ST_IDLE) ? '0 : wptr;
    lane      = base_cnt[LANE_W-1:0];
    word      = (lane == '0) ? {WORD_BYTES{PAD_BYTE}} : acc;
    word[{lane, 3'b000} +: 8] = bus.s_data;

    case (state)
      // IDLE shares the fill path with the count and pointer forced to zero.
      ST_IDLE, ST_FILL: begin
        if (accept) begin
          acc_nxt  = word;
          cnt_nxt  = base_cnt + CNT_W'(1);
          wr_addr  = base_ptr;
          wr_data  = word;
          wptr_nxt = base_ptr;
          if (lane == LANE_W'(WORD_BYTES - 1) || bus.s_last) begin
            wr_en    = 1'b1;
            wptr_nxt = base_ptr + PTR_W'(1);
          end
          ovf_nxt = 1'b0;
          if (bus.s_last) begin
            state_nxt = (base_ptr == PTR_W'(NUM_WORDS - 1)) ? ST_LAUNCH : ST_PAD;
          end else if (cnt_nxt == CNT_W'(MAX_BYTES)) begin
            state_nxt = ST_DISCARD;
            ovf_nxt   = 1'b1;
          end else begin
            state_nxt = ST_FILL;
          end
        end
      end
      ST_DISCARD: begin
        if (accept && bus.s_last) state_nxt = ST_LAUNCH;
      end
      ST_PAD: begin
        wr_en    = 1'b1;
        wr_addr  = wptr;
        wr_data  = {WORD_BYTES{PAD_BYTE}};
        wptr_nxt = wptr + PTR_W'(1);
        if (wptr == PTR_W'(NUM_WORDS - 1)) state_nxt = ST_LAUNCH;
      end
      ST_LAUNCH: state_nxt = ST_WAIT;
      ST_WAIT: begin
        if (bus.loader_ready && !lr_q) begin
          state_nxt = ST_IDLE;
          wptr_nxt  = '0;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  payload_word_ram u_ram (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_en   (bus.mem_rd_en),
    .rd_addr (bus.mem_addr),
    .rd_data (bus.data_out)
  );

endmodule
